vd6_seq_gen: RTL

Serial stimulus transmitter for the vd6 sequence-detector interface. It drives the single-bit stream `w` that the detector consumes.
- A parallel pattern and bit count are loaded on `start`.
- The pattern is shifted out LSB-first, one bit per clk, with a qualifying valid.
- Optionally the pattern repeats with an idle gap between passes.
- The block sits in front of the detector in the vd6 test/stimulus path.

---
 rtl/vd6_seq_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vd6_seq_gen.sv
// Serial stimulus transmitter for the vd6 sequence detector: loads a pattern and sends it LSB-first.
// Optional detector reference model (exp_q) is enabled with `define VD6_SEQ_GEN_EXPECT_EN.
module vd6_seq_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             rpt,
  input  logic             stop,
  output logic             w,
  output logic             w_vld,
  output logic             busy,
  output logic             done
`ifdef VD6_SEQ_GEN_EXPECT_EN
  ,
  output logic             exp_q
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             rpt_q, rpt_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       gcnt, gcnt_d;
  logic             w_d, vld_d, busy_d, done_d;

  // Shared pass-launch path used by start, gap expiry and back-to-back repeat.
  logic             load;
  logic [WIDTH-1:0] load_pat;
  logic [CNT_W-1:0] load_len;
  logic [CNT_W-1:0] eff_len;

  assign eff_len = (len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;

  always_comb begin
    state_d  = state;
    sh_d     = sh;
    pat_d    = pat_q;
    len_d    = len_q;
    rpt_d    = rpt_q;
    cnt_d    = cnt;
    gcnt_d   = gcnt;
    w_d      = 1'b0;
    vld_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    load_pat = pat_q;
    load_len = len_q;

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pat_d = pattern;
            len_d = eff_len;
            rpt_d = rpt;
            if (len == '0) begin
              done_d = 1'b1;
            end else begin
              load     = 1'b1;
              load_pat = pattern;
              load_len = eff_len;
            end
          end
        end
        ST_SHIFT: begin
          // cnt holds the bits still to send after the one currently on w
          if (cnt != '0) begin
            w_d    = sh[0];
            vld_d  = 1'b1;
            busy_d = 1'b1;
            sh_d   = sh >> 1;
            cnt_d  = cnt - 1'b1;
          end else begin
            done_d = 1'b1;
            if (!rpt_q) begin
              state_d = ST_IDLE;
            end else if (GAP == 0) begin
              load = 1'b1;
            end else begin
              state_d = ST_GAP;
              busy_d  = 1'b1;
              gcnt_d  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
            end
          end
        end
        ST_GAP: begin
          busy_d = 1'b1;
          if (gcnt != '0) gcnt_d = gcnt - 1'b1;
          else            load   = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (load) begin
        state_d = ST_SHIFT;
        w_d     = load_pat[0];
        vld_d   = 1'b1;
        busy_d  = 1'b1;
        sh_d    = load_pat >> 1;
        cnt_d   = load_len - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      sh    <= '0;
      pat_q <= '0;
      len_q <= '0;
      rpt_q <= 1'b0;
      cnt   <= '0;
      gcnt  <= '0;
      w     <= 1'b0;
      w_vld <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      sh    <= sh_d;
      pat_q <= pat_d;
      len_q <= len_d;
      rpt_q <= rpt_d;
      cnt   <= cnt_d;
      gcnt  <= gcnt_d;
      w     <= w_d;
      w_vld <= vld_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

`ifdef VD6_SEQ_GEN_EXPECT_EN
  // Moore model of the detector, clocked by the bits this block emits.
  typedef enum logic [1:0] {M_A, M_B, M_C, M_F} mstate_t;

  mstate_t m, m_d;
  logic    acc;

  assign acc = (state == ST_IDLE) && start && !stop;

  always_comb begin
    m_d = m;
    if (acc) begin
      m_d = M_A;
    end else if (w_vld) begin
      case (m)
        M_A:     m_d = w ? M_F : M_B;
        M_B:     m_d = w ? M_F : M_C;
        M_C:     m_d = w ? M_F : M_C;
        M_F:     m_d = w ? M_F : M_B;
        default: m_d = M_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m     <= M_A;
      exp_q <= 1'b0;
    end else begin
      m     <= m_d;
      exp_q <= (m_d == M_C) || (m_d == M_F);
    end
  end
`endif

endmodule
